// File: rtl/ika2151_hostwr_if.sv
// Host request/acknowledge and YM2151 (OPM) bus signals shared by ika2151_hostwr and its host.
interface ika2151_hostwr_if;
    logic       req;
    logic [7:0] addr;
    logic [7:0] data;
    logic       busy;
    logic       ack;
    logic       timeout;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       a0;
    logic [7:0] d_out;
    logic       d_oe;
    logic [7:0] d_in;

    modport master (
        output req, addr, data, d_in,
        input  busy, ack, timeout, cs_n, wr_n, rd_n, a0, d_out, d_oe
    );

    modport slave (
        input  req, addr, data, d_in,
        output busy, ack, timeout, cs_n, wr_n, rd_n, a0, d_out, d_oe
    );
endinterface

// File: rtl/ika2151_hostwr.sv
// Performs one OPM register write (address cycle, then data cycle), followed by a post-write wait.
// Define IKA2151_HOSTWR_BUSYPOLL_EN to end that wait by polling the chip busy flag.
module ika2151_hostwr #(
    parameter int unsigned SETUP_CYC     = 1,
    parameter int unsigned STROBE_CYC    = 4,
    parameter int unsigned HOLD_CYC      = 1,
    parameter int unsigned BUSY_WAIT_CYC = 64,
    parameter int unsigned POLL_LIMIT    = 1023
) (
    input logic             i_EMUCLK,
    input logic             i_RST,
    ika2151_hostwr_if.slave bus
);

    typedef enum logic [3:0] {
        StIdle,
        StASetup,
        StAStrobe,
        StAHold,
        StDSetup,
        StDStrobe,
        StDHold,
        StWait,
        StDone
    } state_e;

    localparam logic [15:0] SetupLd  = 16'(SETUP_CYC - 1);
    localparam logic [15:0] StrobeLd = 16'(STROBE_CYC - 1);
    localparam logic [15:0] HoldLd   = 16'(HOLD_CYC - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        timeout_q, timeout_d;
    logic        cnt_zero;

    assign cnt_zero = (cnt_q == 16'd0);

`ifdef IKA2151_HOSTWR_BUSYPOLL_EN
    localparam logic [9:0] PollLast = 10'(POLL_LIMIT - 1);

    // rec_q marks the recovery cycle after a read; finish_q is the decision taken at its sample.
    logic       rec_q, rec_d;
    logic       finish_q, finish_d;
    logic [9:0] reads_q, reads_d;
    logic       unused_cfg;

    assign unused_cfg = ^{BUSY_WAIT_CYC, bus.d_in[6:0]};
`else
    localparam logic [15:0] WaitLd = 16'(BUSY_WAIT_CYC - 1);

    logic unused_cfg;

    assign unused_cfg = ^{POLL_LIMIT, bus.d_in};
`endif

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state_q   <= StIdle;
            cnt_q     <= 16'd0;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            timeout_q <= 1'b0;
`ifdef IKA2151_HOSTWR_BUSYPOLL_EN
            rec_q     <= 1'b0;
            finish_q  <= 1'b0;
            reads_q   <= 10'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            timeout_q <= timeout_d;
`ifdef IKA2151_HOSTWR_BUSYPOLL_EN
            rec_q     <= rec_d;
            finish_q  <= finish_d;
            reads_q   <= reads_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        timeout_d = timeout_q;
`ifdef IKA2151_HOSTWR_BUSYPOLL_EN
        rec_d     = rec_q;
        finish_d  = finish_q;
        reads_d   = reads_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    addr_d    = bus.addr;
                    data_d    = bus.data;
                    timeout_d = 1'b0;
                    cnt_d     = SetupLd;
                    state_d   = StASetup;
                end
            end
            StASetup: begin
                if (cnt_zero) begin
                    cnt_d   = StrobeLd;
                    state_d = StAStrobe;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StAStrobe: begin
                if (cnt_zero) begin
                    cnt_d   = HoldLd;
                    state_d = StAHold;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StAHold: begin
                if (cnt_zero) begin
                    cnt_d   = SetupLd;
                    state_d = StDSetup;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StDSetup: begin
                if (cnt_zero) begin
                    cnt_d   = StrobeLd;
                    state_d = StDStrobe;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StDStrobe: begin
                if (cnt_zero) begin
                    cnt_d   = HoldLd;
                    state_d = StDHold;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StDHold: begin
                if (cnt_zero) begin
                    state_d = StWait;
`ifdef IKA2151_HOSTWR_BUSYPOLL_EN
                    cnt_d    = StrobeLd;
                    rec_d    = 1'b0;
                    finish_d = 1'b0;
                    reads_d  = 10'd0;
`else
                    cnt_d    = WaitLd;
`endif
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StWait: begin
`ifdef IKA2151_HOSTWR_BUSYPOLL_EN
                if (!rec_q) begin
                    // Busy flag is taken on the edge that closes the read strobe.
                    if (cnt_zero) begin
                        rec_d   = 1'b1;
                        reads_d = reads_q + 10'd1;
                        if (!bus.d_in[7]) begin
                            finish_d = 1'b1;
                        end else if (reads_q == PollLast) begin
                            finish_d  = 1'b1;
                            timeout_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end else if (finish_q) begin
                    state_d = StDone;
                end else begin
                    rec_d = 1'b0;
                    cnt_d = StrobeLd;
                end
`else
                if (cnt_zero) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        bus.busy    = (state_q != StIdle);
        bus.ack     = 1'b0;
        bus.timeout = 1'b0;
        bus.cs_n    = 1'b1;
        bus.wr_n    = 1'b1;
        bus.rd_n    = 1'b1;
        bus.a0      = 1'b0;
        bus.d_out   = 8'h00;
        bus.d_oe    = 1'b0;
        unique case (state_q)
            StASetup, StAStrobe, StAHold: begin
                bus.cs_n  = 1'b0;
                bus.d_out = addr_q;
                bus.d_oe  = 1'b1;
                bus.wr_n  = (state_q != StAStrobe);
            end
            StDSetup, StDStrobe, StDHold: begin
                bus.cs_n  = 1'b0;
                bus.a0    = 1'b1;
                bus.d_out = data_q;
                bus.d_oe  = 1'b1;
                bus.wr_n  = (state_q != StDStrobe);
            end
            StWait: begin
`ifdef IKA2151_HOSTWR_BUSYPOLL_EN
                if (!rec_q) begin
                    bus.cs_n = 1'b0;
                    bus.a0   = 1'b1;
                    bus.rd_n = 1'b0;
                end
`endif
            end
            StDone: begin
                bus.ack     = 1'b1;
                bus.timeout = timeout_q;
            end
            default: ;
        endcase
        // Reset forces a quiet bus immediately, before the state register has cleared.
        if (i_RST) begin
            bus.busy    = 1'b0;
            bus.ack     = 1'b0;
            bus.timeout = 1'b0;
            bus.cs_n    = 1'b1;
            bus.wr_n    = 1'b1;
            bus.rd_n    = 1'b1;
            bus.a0      = 1'b0;
            bus.d_out   = 8'h00;
            bus.d_oe    = 1'b0;
        end
    end

endmodule

// File: tb/tb_ika2151_hostwr.sv
// Scoreboard bench for ika2151_hostwr: stimulus pushes expected transactions, a bus monitor checks.
module tb_ika2151_hostwr;

    localparam int unsigned PollLimit = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ika2151_hostwr_if bus ();

    ika2151_hostwr #(
        .SETUP_CYC    (1),
        .STROBE_CYC   (4),
        .HOLD_CYC     (1),
        .BUSY_WAIT_CYC(64),
        .POLL_LIMIT   (PollLimit)
    ) dut (
        .i_EMUCLK(clk),
        .i_RST   (rst),
        .bus     (bus)
    );

    typedef struct {
        int         base;
        int         ack_rel;
        bit         tmo;
        logic [7:0] addr;
        logic [7:0] data;
        int         reads;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   busy_reads = 0;

    // Monitor capture state for the transaction in flight.
    int   n_wr, n_rd, rd_len, rd_min, rd_max, cs_first, cs_last;
    int   wr_start[2], wr_len[2], wr_a0[2], wr_d[2];
    bit   wr_bad, rd_bad;
    int   overlap_err = 0;
    int   idle_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic void clear_capture();
        n_wr = 0; n_rd = 0; rd_len = 0; rd_min = 999; rd_max = 0;
        cs_first = -1; cs_last = -1; wr_bad = 0; rd_bad = 0;
        for (int i = 0; i < 2; i++) begin
            wr_start[i] = -100; wr_len[i] = 0; wr_a0[i] = -1; wr_d[i] = -1;
        end
    endfunction

    function automatic void push_exp(input int base, input logic [7:0] a, input logic [7:0] d,
                                     input int br);
        exp_t e;
        e.base = base;
        e.addr = a;
        e.data = d;
`ifdef IKA2151_HOSTWR_BUSYPOLL_EN
        e.reads   = (br >= int'(PollLimit)) ? int'(PollLimit) : br + 1;
        e.tmo     = (br >= int'(PollLimit));
        e.ack_rel = 13 + 5 * e.reads;
`else
        e.reads   = 0;
        e.tmo     = 0;
        e.ack_rel = 77;
`endif
        sbq.push_back(e);
    endfunction

    initial begin : monitor
        bit prev_wr, prev_rd, prev_ack;
        int lbl;
        exp_t e;
        prev_wr = 1; prev_rd = 1; prev_ack = 0;
        bus.d_in = 8'h00;
        clear_capture();
        forever begin
            @(posedge clk);
            #1;
            lbl = cyc + 1;
            if (rst) begin
                clear_capture();
                prev_wr = 1; prev_rd = 1; prev_ack = 0;
                bus.d_in = 8'h00;
                continue;
            end
            if (!bus.wr_n && !bus.rd_n) overlap_err++;
            if (bus.cs_n && (bus.d_oe || bus.d_out != 8'h00)) idle_err++;
            if (!bus.d_oe && bus.d_out != 8'h00) idle_err++;
            if (!bus.busy && !bus.cs_n) idle_err++;
            if (bus.timeout && !bus.ack) idle_err++;
            if (!bus.cs_n && bus.d_oe) begin
                if (cs_first < 0) cs_first = lbl;
                cs_last = lbl;
            end
            if (!bus.wr_n) begin
                if (prev_wr) begin
                    if (n_wr < 2) begin
                        wr_start[n_wr] = lbl;
                        wr_len[n_wr]   = 0;
                        wr_a0[n_wr]    = int'(bus.a0);
                        wr_d[n_wr]     = int'(bus.d_out);
                    end
                    n_wr++;
                end
                if (n_wr <= 2) begin
                    wr_len[n_wr-1]++;
                    if (int'(bus.a0) != wr_a0[n_wr-1] || int'(bus.d_out) != wr_d[n_wr-1] ||
                        bus.cs_n || !bus.d_oe) wr_bad = 1;
                end
            end
            if (!bus.rd_n) begin
                if (prev_rd) begin
                    n_rd++;
                    rd_len = 0;
                end
                rd_len++;
                if (bus.cs_n || !bus.a0 || bus.d_oe) rd_bad = 1;
            end else if (!prev_rd) begin
                if (rd_len < rd_min) rd_min = rd_len;
                if (rd_len > rd_max) rd_max = rd_len;
            end
            bus.d_in = (!bus.rd_n && n_rd <= busy_reads) ? 8'h80 : 8'h00;
            if (prev_ack) check("ack_one_cycle", int'(bus.ack), 0);
            if (bus.ack) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("ack_cycle", lbl - e.base, e.ack_rel);
                    check("timeout_flag", int'(bus.timeout), int'(e.tmo));
                    check("wr_pulse_count", n_wr, 2);
                    check("addr_wr_start", wr_start[0] - e.base, 2);
                    check("addr_wr_len", wr_len[0], 4);
                    check("addr_wr_a0", wr_a0[0], 0);
                    check("addr_wr_d", wr_d[0], int'(e.addr));
                    check("data_wr_start", wr_start[1] - e.base, 8);
                    check("data_wr_len", wr_len[1], 4);
                    check("data_wr_a0", wr_a0[1], 1);
                    check("data_wr_d", wr_d[1], int'(e.data));
                    check("wr_stable", int'(wr_bad), 0);
                    check("cs_first", cs_first - e.base, 1);
                    check("cs_last", cs_last - e.base, 12);
                    check("rd_pulse_count", n_rd, e.reads);
                    if (e.reads > 0) begin
                        check("rd_len_min", rd_min, 4);
                        check("rd_len_max", rd_max, 4);
                        check("rd_bus_ctl", int'(rd_bad), 0);
                    end
                end
                clear_capture();
            end
            prev_wr = bus.wr_n; prev_rd = bus.rd_n; prev_ack = bus.ack;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || sbq.size() != 0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) check("wait_idle_bound", 0, 1);
    endtask

    task automatic do_req(input logic [7:0] a, input logic [7:0] d, input int br);
        wait_idle();
        busy_reads = br;
        bus.req  = 1'b1;
        bus.addr = a;
        bus.data = d;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        push_exp(cyc, a, d, br);
    endtask

    initial begin : stimulus
        int base1, base2, n;
        rst = 1'b1;
        bus.req = 1'b0;
        bus.addr = 8'h00;
        bus.data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", int'(bus.cs_n), 1);
        check("rst_wr_n", int'(bus.wr_n), 1);
        check("rst_rd_n", int'(bus.rd_n), 1);
        check("rst_a0", int'(bus.a0), 0);
        check("rst_d", int'(bus.d_out), 0);
        check("rst_d_oe", int'(bus.d_oe), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ack", int'(bus.ack), 0);
        check("rst_timeout", int'(bus.timeout), 0);
        bus.req = 1'b1;
        bus.addr = 8'h99;
        @(posedge clk);
        #1;
        check("rst_beats_req", int'(bus.busy), 0);
        bus.req = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_reset", int'(bus.busy), 0);

        do_req(8'h20, 8'hC7, 0);
        do_req(8'h08, 8'h5A, 0);

        // Second request during the data phase must be dropped.
        do_req(8'h30, 8'h11, 0);
        n = 0;
        while (!(bus.a0 && !bus.cs_n && bus.d_oe) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_data_phase", int'(bus.a0), 1);
        bus.req = 1'b1;
        bus.addr = 8'hAA;
        bus.data = 8'h55;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("no_queued_txn", int'(bus.busy), 0);

        // Reset during the address strobe aborts without an ack.
        bus.req = 1'b1;
        bus.addr = 8'h40;
        bus.data = 8'h22;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        n = 0;
        while (bus.wr_n && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_a_strobe", int'(bus.wr_n), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wr_n", int'(bus.wr_n), 1);
        check("abort_cs_n", int'(bus.cs_n), 1);
        check("abort_busy", int'(bus.busy), 0);
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("abort_stays_idle", int'(bus.busy), 0);
        do_req(8'h41, 8'h23, 0);

        // Request held high: back-to-back transactions.
        wait_idle();
        busy_reads = 0;
        bus.req  = 1'b1;
        bus.addr = 8'h50;
        bus.data = 8'h66;
        @(posedge clk);
        #1;
        base1 = cyc;
        push_exp(base1, 8'h50, 8'h66, 0);
        base2 = base1 + sbq[sbq.size()-1].ack_rel + 1;
        push_exp(base2, 8'h51, 8'h67, 0);
        bus.addr = 8'h51;
        bus.data = 8'h67;
        while (cyc < base2) begin
            @(posedge clk);
            #1;
        end
        bus.req = 1'b0;
        check("b2b_accept", int'(bus.busy), 1);

`ifdef IKA2151_HOSTWR_BUSYPOLL_EN
        do_req(8'h20, 8'hC7, 2);
        do_req(8'h60, 8'h77, 1000);
        do_req(8'h61, 8'h78, 1);
`endif

        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", sbq.size(), 0);
        check("wr_rd_overlap", overlap_err, 0);
        check("idle_bus_quiet", idle_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ika2151_hostwr.md
IKA2151_HOSTWR -- requirements
Module: ika2151_hostwr

Interface
REQ-001 Parameters SHALL be: SETUP_CYC, 1, cycles /CS and A0 and D are valid before the strobe; STROBE_CYC, 4, width of the /WR or /RD low pulse; HOLD_CYC, 1, cycles after strobe release before /CS rises; BUSY_WAIT_CYC, 64, fixed post-data wait (non-poll build); POLL_LIMIT, 1023, maximum status reads before timeout.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 i_EMUCLK  in  1  master clock; all state changes on its rising edge.
REQ-004 i_RST  in  1  synchronous active-high reset.
REQ-005 i_REQ  in  1  write request, sampled only in IDLE.
REQ-006 i_ADDR  in  8  OPM register address.
REQ-007 i_DATA  in  8  OPM register data.
REQ-008 o_BUSY  out  1  high whenever the state is not IDLE.
REQ-009 o_ACK  out  1  one-cycle completion pulse.
REQ-010 o_TIMEOUT  out  1  one-cycle pulse, coincident with o_ACK, when the poll limit is exhausted.
REQ-011 o_CS_n, o_WR_n, o_RD_n, o_A0  out  1 each  OPM bus controls toward the chip.
REQ-012 o_D  out  8  bus write data; o_D_OE  out  1  high while o_D drives the bus.
REQ-013 i_D  in  8  bus read data; bit 7 is the OPM busy flag.

Function
REQ-014 FSM states SHALL be: IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, WAIT, DONE.
REQ-015 IDLE with i_REQ=1 SHALL latch i_ADDR and i_DATA, then enter A_SETUP on the next edge; i_REQ in any other state SHALL be ignored and nothing is queued.
REQ-016 Each SETUP, STROBE and HOLD state SHALL last exactly SETUP_CYC, STROBE_CYC and HOLD_CYC cycles respectively; a downcounter is loaded on state entry.
REQ-017 A_* states SHALL drive o_CS_n=0, o_A0=0, o_D=latched address, o_D_OE=1; o_WR_n=0 only in A_STROBE.
REQ-018 D_* states SHALL drive o_CS_n=0, o_A0=1, o_D=latched data, o_D_OE=1; o_WR_n=0 only in D_STROBE.
REQ-019 A_HOLD SHALL go directly to D_SETUP; D_HOLD SHALL go to WAIT.
REQ-020 DONE SHALL last one cycle with o_ACK=1, then return to IDLE; o_BUSY is still 1 in the DONE cycle.
REQ-021 Outside the A_* and D_* states: o_CS_n=1 except during a poll read, o_WR_n=1, o_D_OE=0, o_D=8'h00.
REQ-022 o_RD_n and o_WR_n SHALL never be low in the same cycle.
REQ-023 From the accepting edge, the address phase SHALL occupy cycles 1..S+W+H and the data phase the next S+W+H cycles (S, W, H = SETUP_CYC, STROBE_CYC, HOLD_CYC).

Reset
REQ-024 While i_RST=1 the next state SHALL be IDLE, and the outputs SHALL be: o_CS_n=o_WR_n=o_RD_n=1, o_A0=0, o_D=0, o_D_OE=0, o_BUSY=0, o_ACK=0, o_TIMEOUT=0.
REQ-025 i_RST SHALL win over a simultaneous i_REQ.
REQ-026 Reset mid-operation SHALL release all strobes at the next edge and SHALL produce no o_ACK.

Configuration
REQ-027 Macro IKA2151_HOSTWR_BUSYPOLL_EN SHALL select how the WAIT state ends.
REQ-028 Macro undefined: WAIT SHALL last exactly BUSY_WAIT_CYC cycles with the bus idle, then go to DONE; o_TIMEOUT stays 0.
REQ-029 Macro defined, poll cycle: WAIT SHALL repeat status reads, each read being o_CS_n=0 and o_A0=1 throughout, o_RD_n=0 for STROBE_CYC cycles, then one recovery cycle with o_CS_n=o_RD_n=1.
REQ-030 Macro defined, poll sampling: i_D[7] SHALL be sampled in the last o_RD_n=0 cycle; 0 leads to DONE after recovery, 1 leads to another read.
REQ-031 Macro defined, poll limit: a 10-bit read counter SHALL cap reads at POLL_LIMIT; on the final read still returning busy, the block SHALL enter DONE with o_TIMEOUT=1.

Verification
REQ-032 Defaults, no macro, REQ at edge k with ADDR=8'h20, DATA=8'hC7 -> o_WR_n low for k+2..k+5 with A0=0 and D=20, low for k+8..k+11 with A0=1 and D=C7, o_ACK only at k+77.
REQ-033 Macro defined, i_D[7]=1 for the first two reads then 0 -> exactly 3 o_RD_n pulses of 4 cycles each, o_ACK at k+28, o_TIMEOUT=0.
REQ-034 Macro defined, POLL_LIMIT=3, i_D[7] stuck at 1 -> 3 reads, then o_ACK=o_TIMEOUT=1 together for one cycle.
REQ-035 Second i_REQ pulsed during the data phase -> ignored; exactly one o_ACK; the second address never appears on o_D.
REQ-036 i_RST asserted in A_STROBE -> next cycle o_WR_n=o_CS_n=1, o_BUSY=0; no o_ACK; the next i_REQ completes normally.
REQ-037 i_REQ held high continuously -> back-to-back transactions, each starting the cycle after o_ACK's IDLE cycle.
